// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for the Mini SRC datapath.
// Steps fetch (T0-T2) and opcode-specific execute states (T3-T7) and drives
// every datapath strobe combinationally from the state register and live ir.
// Optional feature macro: SEQ_SINGLE_STEP_EN adds a step_en input that gates
// every T-state transition (RESET->T0, ->HALT and clear are not gated).
// Handshake: in T1, ld T6 and st T7 the memory strobes stay asserted and the
// state holds until mem_rdy is sampled high; the FSM advances on that edge.
module control_sequencer (
  input  logic        clk,
  input  logic        clear,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic        step_en,
`endif
  input  logic [31:0] ir,
  input  logic        mem_rdy,
  output logic [4:0]  bus_select,
  output logic [15:0] reg_in,
  output logic        pc_in,
  output logic        ir_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        y_in,
  output logic        z_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        inc_pc,
  output logic        mdr_read,
  output logic        mem_read,
  output logic        mem_write,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic [2:0]  t_state
);

  typedef enum logic [3:0] {
    ST_T0 = 4'd0, ST_T1 = 4'd1, ST_T2 = 4'd2, ST_T3 = 4'd3,
    ST_T4 = 4'd4, ST_T5 = 4'd5, ST_T6 = 4'd6, ST_T7 = 4'd7,
    ST_RESET = 4'd8, ST_HALT = 4'd9
  } state_t;

  state_t state_q, state_d;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       unused_ir;
  logic       is_r, is_i, is_ld, is_ldi, is_st, is_md, is_mfhi, is_mflo, is_halt;
  logic       is_short, adv;
  logic [15:0] ra_hot;

  assign opcode    = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir[14:0];

  assign is_r     = (opcode >= 5'b00011) && (opcode <= 5'b01011);
  assign is_i     = (opcode >= 5'b01100) && (opcode <= 5'b01110);
  assign is_ld    = (opcode == 5'b00000);
  assign is_ldi   = (opcode == 5'b00001);
  assign is_st    = (opcode == 5'b00010);
  assign is_md    = (opcode == 5'b01111) || (opcode == 5'b10000);
  assign is_mfhi  = (opcode == 5'b11000);
  assign is_mflo  = (opcode == 5'b11001);
  assign is_halt  = (opcode == 5'b11011);
  // Instructions that finish in T3 (mfhi, mflo, nop, unknown opcodes).
  assign is_short = !(is_r || is_i || is_ld || is_ldi || is_st || is_md);
  assign ra_hot   = 16'h0001 << ra;

`ifdef SEQ_SINGLE_STEP_EN
  assign adv = step_en;
`else
  assign adv = 1'b1;
`endif

  // State register; clear wins over everything, including memory waits.
  always_ff @(posedge clk) begin
    if (clear) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_T0;
      ST_T0:    if (adv) state_d = ST_T1;
      ST_T1:    if (adv && mem_rdy) state_d = ST_T2;
      ST_T2:    if (adv) state_d = ST_T3;
      ST_T3: begin
        if (is_halt)  state_d = ST_HALT;
        else if (adv) state_d = is_short ? ST_T0 : ST_T4;
      end
      ST_T4:    if (adv) state_d = ST_T5;
      ST_T5:    if (adv) state_d = (is_ld || is_st || is_md) ? ST_T6 : ST_T0;
      ST_T6: begin
        if (is_ld)      begin if (adv && mem_rdy) state_d = ST_T7; end
        else if (is_st) begin if (adv) state_d = ST_T7; end
        else if (adv)   state_d = ST_T0;
      end
      ST_T7: begin
        if (is_st) begin if (adv && mem_rdy) state_d = ST_T0; end
        else if (adv) state_d = ST_T0;
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RESET;
    endcase
  end

  // Moore output decode from state and live ir.
  always_comb begin
    bus_select = 5'd0;
    reg_in     = 16'h0000;
    pc_in      = 1'b0;
    ir_in      = 1'b0;
    mar_in     = 1'b0;
    mdr_in     = 1'b0;
    y_in       = 1'b0;
    z_in       = 1'b0;
    hi_in      = 1'b0;
    lo_in      = 1'b0;
    inc_pc     = 1'b0;
    mdr_read   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_op     = 5'd0;
    run        = 1'b0;
    t_state    = 3'd0;
    if (state_q <= ST_T7) begin
      run     = 1'b1;
      t_state = state_q[2:0];
    end
    case (state_q)
      ST_T0: begin
        bus_select = 5'd20; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; alu_op = 5'b00011;
      end
      ST_T1: begin
        bus_select = 5'd19; pc_in = 1'b1; mem_read = 1'b1; mdr_read = 1'b1; mdr_in = 1'b1;
      end
      ST_T2: begin
        bus_select = 5'd21; ir_in = 1'b1;
      end
      ST_T3: begin
        if (is_r || is_i || is_ld || is_ldi || is_st) begin
          bus_select = {1'b0, rb}; y_in = 1'b1;
        end else if (is_md) begin
          bus_select = {1'b0, ra}; y_in = 1'b1;
        end else if (is_mfhi || is_mflo) begin
          bus_select = is_mfhi ? 5'd16 : 5'd17; reg_in = ra_hot;
        end
      end
      ST_T4: begin
        if (is_r) begin
          bus_select = {1'b0, rc}; z_in = 1'b1; alu_op = opcode;
        end else if (is_i) begin
          bus_select = 5'd23; z_in = 1'b1;
          case (opcode)
            5'b01100: alu_op = 5'b00011;
            5'b01101: alu_op = 5'b00101;
            default:  alu_op = 5'b00110;
          endcase
        end else if (is_ld || is_ldi || is_st) begin
          bus_select = 5'd23; z_in = 1'b1; alu_op = 5'b00011;
        end else if (is_md) begin
          bus_select = {1'b0, rb}; z_in = 1'b1; alu_op = opcode;
        end
      end
      ST_T5: begin
        if (is_r || is_i || is_ldi) begin
          bus_select = 5'd19; reg_in = ra_hot;
        end else if (is_ld || is_st) begin
          bus_select = 5'd19; mar_in = 1'b1;
        end else if (is_md) begin
          bus_select = 5'd19; lo_in = 1'b1;
        end
      end
      ST_T6: begin
        if (is_ld) begin
          mem_read = 1'b1; mdr_read = 1'b1; mdr_in = 1'b1;
        end else if (is_st) begin
          bus_select = {1'b0, ra}; mdr_in = 1'b1;
        end else if (is_md) begin
          bus_select = 5'd18; hi_in = 1'b1;
        end
      end
      ST_T7: begin
        if (is_ld) begin
          bus_select = 5'd21; reg_in = ra_hot;
        end else if (is_st) begin
          mem_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
